// File: rtl/reg_file.sv
// reg_file: APB configuration/status register file bridging the host and the k-means core
module reg_file #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 91
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [addrWidth-1:0] paddr,
  input  logic                 pwrite,
  input  logic                 psel,
  input  logic                 penable,
  input  logic [dataWidth-1:0] pwdata,
  output logic [dataWidth-1:0] prdata,
  output logic                 pready,
  input  logic [3:0]           Reg_num,
  input  logic                 Reg_write,
  input  logic [dataWidth-1:0] Reg_write_data,
  output logic                 interupt,
  output logic                 go_core,
  output logic                 W_R_RAM,
  output logic [dataWidth-1:0] Reg_read_data1,
  output logic [dataWidth-1:0] Reg_read_data2
);
  localparam int NREG = 14;
  logic [dataWidth-1:0] regs [16];
  logic                 apb_we, apb_hit;
  logic [4:0]           idx2;
  assign apb_hit        = paddr < addrWidth'(NREG);
  assign apb_we         = psel & penable & pwrite & pready;
  assign idx2           = {1'b0, Reg_num} + 5'd1;
  assign interupt       = regs[0][0];
  assign prdata         = (psel & ~pwrite & apb_hit) ? regs[paddr[3:0]] : '0;
  assign Reg_read_data1 = (Reg_num < 4'(NREG)) ? regs[Reg_num] : '0;
  assign Reg_read_data2 = (idx2 < 5'(NREG)) ? regs[idx2[3:0]] : '0;
  // register array, strobes and ready; the core wins a same-register collision, GO and 14/15 stay zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      pready  <= 1'b0;
      go_core <= 1'b0;
      W_R_RAM <= 1'b0;
    end else begin
      pready  <= 1'b1;
      go_core <= apb_we & (paddr == addrWidth'(1)) & pwdata[0];
      W_R_RAM <= apb_we & (paddr == addrWidth'(11));
      for (int i = 0; i < NREG; i++) begin
        if (i != 1) begin
          if (Reg_write && Reg_num == 4'(i)) regs[i] <= Reg_write_data;
          else if (apb_we && paddr == addrWidth'(i)) regs[i] <= pwdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed scoreboard bench for reg_file
module tb_reg_file;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  paddr;
  logic        pwrite, psel, penable;
  logic [90:0] pwdata, prdata;
  logic        pready;
  logic [3:0]  Reg_num;
  logic        Reg_write;
  logic [90:0] Reg_write_data;
  logic        interupt, go_core, W_R_RAM;
  logic [90:0] Reg_read_data1, Reg_read_data2;
  int          vectors = 0;
  int          errors = 0;
  logic [90:0] exp_q[$];

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel),
    .penable(penable), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .Reg_num(Reg_num), .Reg_write(Reg_write), .Reg_write_data(Reg_write_data),
    .interupt(interupt), .go_core(go_core), .W_R_RAM(W_R_RAM),
    .Reg_read_data1(Reg_read_data1), .Reg_read_data2(Reg_read_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [90:0] obs, input logic [90:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [90:0] obs);
    if (exp_q.size() == 0) begin
      vectors++;
      errors++;
      $error("FAIL %s: scoreboard empty, got %0h", tag, obs);
    end else chk(tag, obs, exp_q.pop_front());
  endtask

  // returns #1 after the commit edge, when the strobes are visible
  task automatic apb_wr(input logic [7:0] a, input logic [90:0] d);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, input logic [90:0] e, input string tag);
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #3 pop_chk(tag, prdata);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; paddr = '0; pwrite = 1'b0; psel = 1'b0; penable = 1'b0; pwdata = '0;
    Reg_num = '0; Reg_write = 1'b0; Reg_write_data = '0;
    #2;
    chk("rst_pready", 91'(pready), 91'd0);
    chk("rst_go", 91'(go_core), 91'd0);
    chk("rst_wr_ram", 91'(W_R_RAM), 91'd0);
    chk("rst_int", 91'(interupt), 91'd0);
    chk("rst_prdata", prdata, 91'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("pready_up", 91'(pready), 91'd1);
    for (int i = 0; i < 14; i++) apb_rd(8'(i), 91'd0, "reset_read");

    Reg_num = 4'd10;
    apb_wr(8'd10, 91'd1);
    chk("no_wr_ram_addr", 91'(W_R_RAM), 91'd0);
    apb_wr(8'd11, 91'd6);
    chk("wr_ram_pulse", 91'(W_R_RAM), 91'd1);
    chk("rd1_addr", Reg_read_data1, 91'd1);
    chk("rd2_data", Reg_read_data2, 91'd6);
    @(posedge clk); #1;
    chk("wr_ram_end", 91'(W_R_RAM), 91'd0);

    apb_wr(8'd1, 91'd1);
    chk("go_pulse", 91'(go_core), 91'd1);
    @(posedge clk); #1;
    chk("go_end", 91'(go_core), 91'd0);
    apb_rd(8'd1, 91'd0, "go_readback");
    apb_wr(8'd1, 91'd0);
    chk("go_zero_nopulse", 91'(go_core), 91'd0);

    apb_wr(8'd10, 91'd1);
    apb_wr(8'd11, 91'd7);
    chk("wr_ram_pulse2", 91'(W_R_RAM), 91'd1);
    chk("rd2_data2", Reg_read_data2, 91'd7);
    apb_wr(8'd11, 91'd8);
    chk("wr_ram_b2b", 91'(W_R_RAM), 91'd1);
    chk("rd2_data3", Reg_read_data2, 91'd8);
    apb_wr(8'd4, 91'h123);
    apb_rd(8'd4, 91'h123, "cent3_read");
    apb_wr(8'd9, {1'b1, 90'h2_dead_beef_cafe_f00d});
    apb_rd(8'd9, {1'b1, 90'h2_dead_beef_cafe_f00d}, "cent8_wide");

    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'd3; pwdata = 91'h55;
    @(posedge clk); #1;
    psel = 1'b0; pwrite = 1'b0;
    apb_rd(8'd3, 91'd0, "setup_only_write");

    @(posedge clk); #1;
    Reg_write = 1'b1; Reg_num = 4'd0; Reg_write_data = 91'd1;
    @(posedge clk); #1;
    Reg_write = 1'b0;
    chk("int_set", 91'(interupt), 91'd1);
    apb_wr(8'd0, 91'd0);
    chk("int_clr", 91'(interupt), 91'd0);

    @(posedge clk); #1;
    Reg_write = 1'b1; Reg_num = 4'd1; Reg_write_data = 91'd1;
    @(posedge clk); #1;
    Reg_write = 1'b0;
    chk("core_go_nopulse", 91'(go_core), 91'd0);
    apb_rd(8'd1, 91'd0, "core_go_ignored");

    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'd2; pwdata = 91'hAAA;
    @(posedge clk); #1;
    penable = 1'b1; Reg_write = 1'b1; Reg_num = 4'd2; Reg_write_data = 91'hBBB;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; Reg_write = 1'b0;
    apb_rd(8'd2, 91'hBBB, "collision_core_wins");

    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'd5; pwdata = 91'h444;
    @(posedge clk); #1;
    penable = 1'b1; Reg_write = 1'b1; Reg_num = 4'd3; Reg_write_data = 91'h333;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; Reg_write = 1'b0;
    apb_rd(8'd5, 91'h444, "dual_apb");
    apb_rd(8'd3, 91'h333, "dual_core");

    apb_wr(8'd13, 91'h99);
    Reg_num = 4'd12;
    #1 chk("rd2_last", Reg_read_data2, 91'h99);
    Reg_num = 4'd13;
    #1 chk("rd1_13", Reg_read_data1, 91'h99);
    chk("rd2_13_zero", Reg_read_data2, 91'd0);
    Reg_num = 4'd15;
    #1 chk("rd1_15_zero", Reg_read_data1, 91'd0);

    apb_wr(8'd20, 91'h77);
    apb_rd(8'd20, 91'd0, "unmapped_read");
    apb_wr(8'd14, 91'h77);
    apb_rd(8'd14, 91'd0, "unmapped14_read");

    Reg_num = 4'd10;
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'd11; pwdata = 91'h9;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_wr_ram", 91'(W_R_RAM), 91'd0);
    chk("rst_mid_data", Reg_read_data2, 91'd0);
    chk("rst_mid_addr", Reg_read_data1, 91'd0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_wr_ram", 91'(W_R_RAM), 91'd0);
    apb_rd(8'd11, 91'd0, "post_rst_ram_data");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
